// File: rtl/display_pkg.sv
// Shared constants and types for the display arbiter slice.
//   DIGIT_W / NUM_DIGITS / FRAME_W : geometry of one 4-digit hex frame
//   IDLE_VAL_DEFAULT               : frame shown while nothing is granted
//   state_e                        : arbiter FSM states
package display_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned FRAME_W    = DIGIT_W * NUM_DIGITS;

  localparam logic [FRAME_W-1:0] IDLE_VAL_DEFAULT = 16'h0000;

  typedef enum logic [0:0] {
    IDLE,
    SHOW
  } state_e;

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle between the application sources and the display arbiter.
//   req  : per-source level-sensitive request
//   data : source i frame at [FRAME_W*i +: FRAME_W]
//   gnt  : one-hot grant (all zero when idle)
//   busy : any grant active
//   dig1..dig4 : granted frame, rightmost digit first
// master = source side, slave = arbiter side.
interface display_arbiter_if
  import display_pkg::*;
#(
  parameter int unsigned NUM_SRC = 4
);
  logic [NUM_SRC-1:0]         req;
  logic [FRAME_W*NUM_SRC-1:0] data;
  logic [NUM_SRC-1:0]         gnt;
  logic                       busy;
  logic [DIGIT_W-1:0]         dig1;
  logic [DIGIT_W-1:0]         dig2;
  logic [DIGIT_W-1:0]         dig3;
  logic [DIGIT_W-1:0]         dig4;

  modport master (
    output req, data,
    input  gnt, busy, dig1, dig2, dig3, dig4
  );

  modport slave (
    input  req, data,
    output gnt, busy, dig1, dig2, dig3, dig4
  );
endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker.
//   req             : request vector
//   last_gnt        : index of the last granted source; scan starts one above it
//   exclude_current : drop last_gnt itself from the candidates (rotation/release)
//   pick            : one-hot winner (zero when none)
//   valid           : a winner exists
module rr_picker #(
  parameter int unsigned NUM_SRC = 4,
  localparam int unsigned IdxW   = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [IdxW-1:0]    last_gnt,
  input  logic               exclude_current,
  output logic [NUM_SRC-1:0] pick,
  output logic               valid
);

  logic [IdxW:0]   sum;
  logic [IdxW-1:0] cand;

  always_comb begin
    pick  = '0;
    valid = 1'b0;
    sum   = '0;
    cand  = '0;
    // Offsets 1..NUM_SRC so last_gnt itself is visited last.
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      sum = {1'b0, last_gnt} + (IdxW+1)'(k);
      if (sum >= (IdxW+1)'(NUM_SRC)) begin
        sum = sum - (IdxW+1)'(NUM_SRC);
      end
      cand = sum[IdxW-1:0];
      if (!valid && req[cand] && !(exclude_current && (cand == last_gnt))) begin
        pick[cand] = 1'b1;
        valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin sharing of one 4-digit seven-segment display between NUM_SRC sources,
// with a minimum dwell per grant measured in prescaled ticks.
//   clk  : system clock
//   clr  : asynchronous active-low reset
//   bus  : display_arbiter_if.slave (req/data in, gnt/busy/dig1..dig4 out, all registered)
module display_arbiter
  import display_pkg::*;
#(
  parameter int unsigned          NUM_SRC  = 4,
  parameter int unsigned          TICK_DIV = 100000,
  parameter int unsigned          DWELL    = 1000,
  parameter logic [FRAME_W-1:0]   IDLE_VAL = IDLE_VAL_DEFAULT
) (
  input logic              clk,
  input logic              clr,
  display_arbiter_if.slave bus
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);
  localparam int unsigned PreW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned DwW  = (DWELL > 0) ? $clog2(DWELL + 1) : 1;

  state_e              state_q;
  logic [NUM_SRC-1:0]  gnt_q;
  logic                busy_q;
  logic [IdxW-1:0]     last_q;
  logic [DwW-1:0]      dwell_q;
  logic [PreW-1:0]     presc_q;
  logic [FRAME_W-1:0]  frame_q;

  logic                tick;
  logic [NUM_SRC-1:0]  pick;
  logic                pick_valid;
  logic [IdxW-1:0]     pick_idx;
  logic [FRAME_W-1:0]  pick_frame;
  logic [FRAME_W-1:0]  hold_frame;
  logic                release_holder;
  logic                dwell_max;
  logic                handover;

  // Free-running prescaler; grant changes never touch its phase.
  assign tick = (presc_q == PreW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      presc_q <= '0;
    end else if (tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PreW'(1);
    end
  end

  // In SHOW last_q is the current holder, so excluding it rotates away from it.
  rr_picker #(
    .NUM_SRC (NUM_SRC)
  ) u_picker (
    .req             (bus.req),
    .last_gnt        (last_q),
    .exclude_current (state_q == SHOW),
    .pick            (pick),
    .valid           (pick_valid)
  );

  // Only the selected slice reaches the mux output; other sources' data is ignored.
  always_comb begin
    pick_idx   = '0;
    pick_frame = '0;
    hold_frame = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (pick[i]) begin
        pick_idx   = IdxW'(i);
        pick_frame = bus.data[FRAME_W*i +: FRAME_W];
      end
      if (last_q == IdxW'(i)) begin
        hold_frame = bus.data[FRAME_W*i +: FRAME_W];
      end
    end
  end

  assign release_holder = !bus.req[last_q];
  assign dwell_max      = (dwell_q == DwW'(DWELL));
  // Release and rotation share the same pick, so one handover term covers both.
  assign handover       = pick_valid && ((state_q == IDLE) || release_holder || dwell_max);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= IdxW'(NUM_SRC - 1);
      dwell_q <= '0;
      frame_q <= IDLE_VAL;
    end else if (handover) begin
      state_q <= SHOW;
      gnt_q   <= pick;
      busy_q  <= 1'b1;
      last_q  <= pick_idx;
      dwell_q <= '0;
      frame_q <= pick_frame;
    end else if (state_q == SHOW) begin
      if (release_holder) begin
        state_q <= IDLE;
        gnt_q   <= '0;
        busy_q  <= 1'b0;
        frame_q <= IDLE_VAL;
      end else begin
        frame_q <= hold_frame;
        if (tick && !dwell_max) begin
          dwell_q <= dwell_q + DwW'(1);
        end
      end
    end
  end

  assign bus.gnt  = gnt_q;
  assign bus.busy = busy_q;
  assign bus.dig1 = frame_q[3:0];
  assign bus.dig2 = frame_q[7:4];
  assign bus.dig3 = frame_q[11:8];
  assign bus.dig4 = frame_q[15:12];

endmodule

// File: tb/tb_display_arbiter.sv
// Randomized + directed bench for display_arbiter with a scoreboard:
// a reference model pushes the expected post-edge outputs, a monitor pops and compares.
module tb_display_arbiter;

  localparam int N  = 4;
  localparam int TD = 4;
  localparam int DW = 3;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  display_arbiter_if #(.NUM_SRC(N)) bus ();

  display_arbiter #(
    .NUM_SRC  (N),
    .TICK_DIV (TD),
    .DWELL    (DW),
    .IDLE_VAL (16'h0000)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct packed {
    logic [N-1:0] gnt;
    logic         busy;
    logic [15:0]  frame;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state: holder index (-1 = nobody), dwell ticks, last winner.
  int   m_holder = -1;
  int   m_last   = N - 1;
  int   m_dwell  = 0;
  int   m_cyc    = 0;
  bit   m_tick;
  int   m_p;
  exp_t m_e;

  function automatic int rr(logic [N-1:0] r, int last, int excl);
    for (int k = 1; k <= N; k++) begin
      int c = (last + k) % N;
      if (r[c] && c != excl) return c;
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model: what the display must show after each clock edge.
  initial begin
    forever begin
      @(posedge clk or negedge clr);
      if (!clr) begin
        m_holder = -1;
        m_last   = N - 1;
        m_dwell  = 0;
        m_cyc    = 0;
        exp_q.delete();
      end else begin
        m_tick = ((m_cyc % TD) == TD - 1);
        m_cyc++;
        if (m_holder < 0) begin
          m_p = rr(bus.req, m_last, -1);
          if (m_p >= 0) begin
            m_holder = m_p;
            m_last   = m_p;
            m_dwell  = 0;
          end
        end else if (!bus.req[m_holder] || m_dwell == DW) begin
          m_p = rr(bus.req, m_holder, m_holder);
          if (m_p >= 0) begin
            m_holder = m_p;
            m_last   = m_p;
            m_dwell  = 0;
          end else if (!bus.req[m_holder]) begin
            m_holder = -1;
          end
        end else if (m_tick) begin
          m_dwell++;
        end
        m_e.gnt   = (m_holder >= 0) ? N'(1 << m_holder) : '0;
        m_e.busy  = (m_holder >= 0);
        m_e.frame = (m_holder >= 0) ? bus.data[16*m_holder +: 16] : 16'h0000;
        exp_q.push_back(m_e);
      end
    end
  end

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!clr) begin
        chk("reset_gnt", 32'(bus.gnt), 32'h0);
        chk("reset_busy", 32'(bus.busy), 32'h0);
        chk("reset_digits", 32'({bus.dig4, bus.dig3, bus.dig2, bus.dig1}), 32'h0);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty at %0t: got no expectation, required one", $time);
      end else begin
        e = exp_q.pop_front();
        chk("gnt", 32'(bus.gnt), 32'(e.gnt));
        chk("busy", 32'(bus.busy), 32'(e.busy));
        chk("digits", 32'({bus.dig4, bus.dig3, bus.dig2, bus.dig1}), 32'(e.frame));
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    bus.req  = 4'b1111;
    bus.data = {$urandom, $urandom};
    cyc(3);
    clr = 1'b1;
    cyc(3);

    // Single source with live data updates, then a long hold without rotation.
    bus.req          = 4'b0100;
    bus.data[32 +: 16] = 16'h1234;
    cyc(5);
    bus.data[32 +: 16] = 16'hABCD;
    cyc(100);

    // Two-way rotation.
    bus.req = 4'b0011;
    cyc(40);

    // Early release to src3.
    bus.req = 4'b0001;
    cyc(5);
    bus.req = 4'b1000;
    cyc(6);

    // All drop.
    bus.req = 4'b0000;
    cyc(5);

    // Asynchronous reset between edges while showing.
    bus.req = 4'b0011;
    cyc(6);
    @(posedge clk);
    #3;
    clr = 1'b0;
    #1;
    chk("async_gnt", 32'(bus.gnt), 32'h0);
    chk("async_busy", 32'(bus.busy), 32'h0);
    chk("async_digits", 32'({bus.dig4, bus.dig3, bus.dig2, bus.dig1}), 32'h0);
    bus.req = 4'b1010;
    cyc(2);
    clr = 1'b1;
    cyc(10);

    // Random traffic: slowly changing requests, fast-changing data.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(7) == 0) bus.req = 4'($urandom);
      bus.data = {$urandom, $urandom};
      cyc(1);
    end

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/display_arbiter.md
Name: display_arbiter

Overview:
- Shares the single 4-digit seven-segment display between NUM_SRC requesters, each supplying a 16-bit hex frame.
- Grants are round-robin, with a minimum dwell time per requester.
- Drives dig1..dig4 of the display block directly.
- Sits between application sources (counters, switch readers, status) and the display driver.

Parameters:
- NUM_SRC, 4: number of requesters (2..8).
- TICK_DIV, 100000: clk cycles per dwell tick (1 kHz at 100 MHz).
- DWELL, 1000: ticks a grant is held before rotating when others wait (1 s).
- IDLE_VAL, 16'h0000: frame shown when no requester is granted.

Ports:
- clk, input, 1: system clock.
- clr, input, 1: asynchronous, active-low reset.
- req, input, NUM_SRC: per-source display request, level-sensitive.
- data, input, 16*NUM_SRC: source i frame at [16*i +: 16].
- gnt, output, NUM_SRC: one-hot grant, or all zero when idle.
- busy, output, 1: high while any grant is active.
- dig1, output, 4: rightmost digit = granted frame[3:0].
- dig2, output, 4: frame[7:4].
- dig3, output, 4: frame[11:8].
- dig4, output, 4: leftmost digit = frame[15:12].

Behaviour:
- All outputs are registered.
- Reset (clr low, asynchronous) sets:
  - gnt=0, busy=0, dig1..dig4=IDLE_VAL nibbles;
  - state=IDLE, dwell counter=0, prescaler=0;
  - last_gnt=NUM_SRC-1, so src0 wins first.
- Prescaler:
  - Counts 0..TICK_DIV-1 and pulses tick for one cycle at TICK_DIV-1.
  - Free-running; not cleared on grant changes.
- Round-robin pick: the first requester with req=1 scanning from last_gnt+1 upward, wrapping modulo NUM_SRC. The current holder is excluded when rotating.
- FSM state IDLE:
  - gnt=0, digits=IDLE_VAL.
  - If any req is high, the next cycle enters SHOW: gnt=one-hot pick, busy=1, dwell=0, last_gnt=pick.
- FSM state SHOW:
  - Each cycle the digits register data of the granted source: 1-cycle latency, live updates.
  - dwell increments on tick and saturates at DWELL.
- Release (req[gnt] low):
  - Next cycle, hand over to the pick if any other req is high.
  - Otherwise go to IDLE, with gnt=0 and digits=IDLE_VAL.
- Rotation: when dwell==DWELL and another req is high, the next cycle hands over to the pick.
  - If no other request, keep the grant (dwell stays saturated).
  - A newcomer then rotates in on the next cycle.
- Every handover is direct: gnt goes one-hot to one-hot with no all-zero cycle, and dwell is cleared.
- Digits always match gnt in the same cycle; frames from non-granted sources never reach the output.
- Dwell duration is between DWELL-1 and DWELL tick periods, because the prescaler phase is free.
- Simultaneous events:
  - Release and rotation in the same cycle: treated as a release, same pick.
  - Request arriving in the same cycle as a release: eligible immediately.
- X/undefined data of non-granted sources is ignored.

Decomposition:
- Package display_pkg holds:
  - DIGIT_W=4, NUM_DIGITS=4, FRAME_W=16;
  - the state enum (IDLE, SHOW);
  - the IDLE_VAL default.
- One sub-module: rr_picker. It is purely combinational, with inputs req, last_gnt and exclude_current, and outputs one-hot pick and valid.
- The prescaler is inline in the top level.

Test Plan (TICK_DIV=4, DWELL=3, NUM_SRC=4):
- Reset: hold clr=0 with req=4'b1111 -> gnt=0, busy=0, digits=0. Release clr -> 1 cycle later gnt=4'b0001.
- Single source: req=4'b0100, data slice 2 = 16'h1234 -> 1 cycle later gnt=4'b0100, dig1=4, dig2=3, dig3=2, dig4=1. Change data to 16'hABCD -> digits follow 1 cycle later. Hold 100 cycles -> no rotation.
- Rotation: req=4'b0011 -> gnt=0001. After the 3rd tick -> gnt=0010 with no zero-gnt cycle. After 3 more ticks -> gnt=0001.
- Early release: src0 granted, req drops to 4'b1000 -> next cycle gnt=1000, digits=src3 frame, dwell restarts.
- All drop: req -> 0 while in SHOW -> next cycle gnt=0, busy=0, digits=IDLE_VAL.
- Reset mid-operation: assert clr=0 mid-SHOW, asynchronously between clock edges -> gnt=0 immediately. After release with req=4'b1010 -> gnt=0010 first.
